// File: rtl/gat_stage_scheduler.sv
// -----------------------------------------------------------------------------
// gat_stage_scheduler
//
// Token-based scheduler for the four GAT layer stages:
//   stage 0 SPMM (sparse H x W), 1 DMVM (attention coefficients),
//   stage 2 SM (softmax),        3 AGGR (aggregation).
// A batch of N sub-graphs is pushed through the stages in pipeline fashion.
// Each stage gets a registered one-cycle start pulse and reports completion
// with a one-cycle vld pulse. A stage may run ahead of its downstream
// neighbour by at most BUF_DEPTH results (inter-stage result slots).
//
// Parameters:
//   SG_W       width of sub-graph counters and num_subgraph_i
//   BUF_DEPTH  result slots between consecutive stages (legal 1..4)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start_i                     run command pulse, sampled only in IDLE
//   num_subgraph_i [SG_W]       batch size N, latched on accepted start_i
//   busy_o                      high in RUN and DONE
//   done_o                      one-cycle pulse when the batch completes
//   err_o                       sticky: vld from a stage that was not busy
//   <stage>_start_o             registered one-cycle start pulse per stage
//   <stage>_rdy_i               stage can accept a start
//   <stage>_vld_i               one-cycle completion pulse per stage
//   cur_subgraph_o [SG_W]       sub-graphs completed by AGGR
//   perf_cycles_o [32]          RUN cycle count
//   perf_stall_o  [32]          RUN cycles with a stage blocked by !rdy or
//                               a full downstream buffer
//
// Build option:
//   GAT_SCHED_PERF_EN  when defined, builds the saturating performance
//                      counters; otherwise perf_cycles_o/perf_stall_o are 0.
// -----------------------------------------------------------------------------
module gat_stage_scheduler #(
  parameter int unsigned SG_W      = 16,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [SG_W-1:0] num_subgraph_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            spmm_start_o,
  output logic            dmvm_start_o,
  output logic            sm_start_o,
  output logic            aggr_start_o,
  input  logic            spmm_rdy_i,
  input  logic            dmvm_rdy_i,
  input  logic            sm_rdy_i,
  input  logic            aggr_rdy_i,
  input  logic            spmm_vld_i,
  input  logic            dmvm_vld_i,
  input  logic            sm_vld_i,
  input  logic            aggr_vld_i,
  output logic [SG_W-1:0] cur_subgraph_o,
  output logic [31:0]     perf_cycles_o,
  output logic [31:0]     perf_stall_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [SG_W-1:0] BUF_LIM = SG_W'(BUF_DEPTH);

  state_t          state_q;
  state_t          state_d;

  logic [SG_W-1:0] n_q;
  logic [SG_W-1:0] issued_q [4];
  logic [SG_W-1:0] cmpl_q   [4];
  logic [3:0]      busy_q;
  logic [3:0]      start_q;
  logic            err_q;

  // Per-stage vectors, index 0..3 = SPMM, DMVM, SM, AGGR.
  logic [3:0]      rdy;
  logic [3:0]      vld;
  logic [3:0]      avail;   // upstream has produced work not yet issued
  logic [3:0]      room;    // downstream result slot free
  logic [3:0]      issue;
  logic            accept;
  logic            in_run;
  logic [SG_W-1:0] aggr_cmpl_nxt;

  assign rdy    = {aggr_rdy_i, sm_rdy_i, dmvm_rdy_i, spmm_rdy_i};
  assign vld    = {aggr_vld_i, sm_vld_i, dmvm_vld_i, spmm_vld_i};
  assign accept = (state_q == ST_IDLE) && start_i;
  assign in_run = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Issue decision, evaluated purely on registered state. issued[s+1] never
  // exceeds cmpl[s], so the buffer-occupancy subtraction cannot wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    avail    = '0;
    room     = '0;
    avail[0] = (issued_q[0] < n_q);
    for (int unsigned s = 1; s < 4; s++) begin
      avail[s] = (issued_q[s] < cmpl_q[s-1]);
    end
    for (int unsigned s = 0; s < 3; s++) begin
      room[s] = ((cmpl_q[s] - issued_q[s+1]) < BUF_LIM);
    end
    room[3] = 1'b1;
    issue   = in_run ? (~busy_q & rdy & ~start_q & avail & room) : '0;
  end

  // Completion count including a completion arriving this cycle, so that
  // done_o follows the final aggr_vld_i by exactly one cycle.
  assign aggr_cmpl_nxt = cmpl_q[3] + SG_W'(vld[3] & busy_q[3]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN:  if (aggr_cmpl_nxt == n_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control state and per-stage token tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      busy_q  <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned s = 0; s < 4; s++) begin
        issued_q[s] <= '0;
        cmpl_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      start_q <= issue;

      if (accept) begin
        n_q    <= num_subgraph_i;
        busy_q <= '0;
        for (int unsigned s = 0; s < 4; s++) begin
          issued_q[s] <= '0;
          cmpl_q[s]   <= '0;
        end
      end else begin
        // Issue needs !busy and a completion needs busy, so for a legal
        // stage the two branches never fire on the same edge.
        for (int unsigned s = 0; s < 4; s++) begin
          if (issue[s]) begin
            busy_q[s]   <= 1'b1;
            issued_q[s] <= issued_q[s] + 1'b1;
          end
          if (vld[s] && busy_q[s]) begin
            busy_q[s] <= 1'b0;
            cmpl_q[s] <= cmpl_q[s] + 1'b1;
          end
        end
      end

      if (accept) begin
        err_q <= 1'b0;
      end else if (|(vld & ~busy_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = err_q;
  assign spmm_start_o   = start_q[0];
  assign dmvm_start_o   = start_q[1];
  assign sm_start_o     = start_q[2];
  assign aggr_start_o   = start_q[3];
  assign cur_subgraph_o = cmpl_q[3];

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef GAT_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [31:0] perf_stall_q;
  logic        stall_now;

  // A stage is stalled when it has work and is idle, but its ready is low or
  // its downstream buffer is full.
  assign stall_now = in_run && (|(avail & ~busy_q & (~rdy | ~room)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (accept) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else if (in_run) begin
      if (perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 1'b1;
      if (stall_now && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
    end
  end

  assign perf_cycles_o = perf_cycles_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_cycles_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule

// File: tb/tb_gat_stage_scheduler.sv
module tb_gat_stage_scheduler;

  localparam int unsigned SG_W = 16;
  localparam int unsigned BD   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start_i;
  logic [SG_W-1:0] num_subgraph_i;
  logic [3:0]      t_rdy;
  logic [3:0]      t_vld;
  logic            busy_o, done_o, err_o;
  logic            spmm_start_o, dmvm_start_o, sm_start_o, aggr_start_o;
  logic [SG_W-1:0] cur_subgraph_o;
  logic [31:0]     perf_cycles_o, perf_stall_o;
  logic [3:0]      starts;

  assign starts = {aggr_start_o, sm_start_o, dmvm_start_o, spmm_start_o};

  gat_stage_scheduler #(.SG_W(SG_W), .BUF_DEPTH(BD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .num_subgraph_i (num_subgraph_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .spmm_start_o   (spmm_start_o),
    .dmvm_start_o   (dmvm_start_o),
    .sm_start_o     (sm_start_o),
    .aggr_start_o   (aggr_start_o),
    .spmm_rdy_i     (t_rdy[0]),
    .dmvm_rdy_i     (t_rdy[1]),
    .sm_rdy_i       (t_rdy[2]),
    .aggr_rdy_i     (t_rdy[3]),
    .spmm_vld_i     (t_vld[0]),
    .dmvm_vld_i     (t_vld[1]),
    .sm_vld_i       (t_vld[2]),
    .aggr_vld_i     (t_vld[3]),
    .cur_subgraph_o (cur_subgraph_o),
    .perf_cycles_o  (perf_cycles_o),
    .perf_stall_o   (perf_stall_o)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    int n;
    int start_cyc;
  } exp_t;
  exp_t sb_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor: reference bookkeeping of token flow and scoreboard pop on done_o
  // ---------------------------------------------------------------------------
  bit m_active = 0;
  int m_n = 0;
  int vcnt[4];
  int vcnt_prev[4];
  int scnt[4];
  bit outst[4];
  bit prev_rdy[4];
  bit prev_vld[4];
  int last_aggr_vld = 0;
  int batches_done = 0;
  bit chk_idle = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      chk_idle = 0;
    end else begin
      if (chk_idle) begin
        check("busy_after_done", busy_o, 0);
        chk_idle = 0;
      end
      if (m_active) begin
        for (int s = 0; s < 4; s++) begin
          if (starts[s]) begin
            if (s == 0) check("spmm_issue_limit", scnt[0] < m_n, 1);
            else check($sformatf("order_s%0d", s), scnt[s] < vcnt_prev[s-1], 1);
            if (s < 3) check($sformatf("room_s%0d", s), (vcnt_prev[s] - scnt[s+1]) < BD, 1);
            check($sformatf("rdy_s%0d", s), prev_rdy[s], 1);
            check($sformatf("idle_s%0d", s), !outst[s] && !prev_vld[s], 1);
          end
        end
        if (done_o) begin
          if (sb_q.size() == 0) begin
            check("done_no_expect", done_o, 0);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.n == 0) check("done_latency_n0", cyc, e.start_cyc + 2);
            else check("done_latency", cyc, last_aggr_vld + 1);
            check("cur_subgraph", cur_subgraph_o, e.n);
            for (int s = 0; s < 4; s++)
              check($sformatf("start_count_s%0d", s), scnt[s] + int'(starts[s]), e.n);
            check("err_at_done", err_o, 0);
            check("busy_at_done", busy_o, 1);
          end
          m_active = 0;
          chk_idle = 1;
          batches_done++;
        end
        for (int s = 0; s < 4; s++) begin
          if (t_vld[s]) outst[s] = 0;
          if (starts[s]) outst[s] = 1;
          vcnt_prev[s] = vcnt[s];
          vcnt[s] += int'(t_vld[s]);
          scnt[s] += int'(starts[s]);
          prev_rdy[s] = t_rdy[s];
          prev_vld[s] = t_vld[s];
        end
        if (t_vld[3]) last_aggr_vld = cyc;
      end else begin
        if (|starts) check("stray_start", starts, 0);
        if (done_o) check("stray_done", done_o, 0);
        if (start_i) begin
          m_active = 1;
          m_n = int'(num_subgraph_i);
          for (int s = 0; s < 4; s++) begin
            vcnt[s] = 0; vcnt_prev[s] = 0; scnt[s] = 0; outst[s] = 0;
            prev_rdy[s] = t_rdy[s]; prev_vld[s] = 0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver and stage responders
  // ---------------------------------------------------------------------------
  int         timer[4];
  int         lat_min = 5;
  int         lat_max = 5;
  bit         rdy_rand = 0;
  logic [3:0] rdy_force_lo = '0;

  task automatic step();
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) begin
      t_vld[s] = 1'b0;
      if (timer[s] > 0) begin
        timer[s]--;
        if (timer[s] == 0) t_vld[s] = 1'b1;
      end
      if (starts[s]) timer[s] = $urandom_range(lat_max, lat_min);
      if (rdy_force_lo[s]) t_rdy[s] = 1'b0;
      else if (rdy_rand) t_rdy[s] = ($urandom_range(3, 0) != 0);
      else t_rdy[s] = 1'b1;
    end
    start_i = 1'b0;
  endtask

  task automatic start_batch(int n);
    exp_t e;
    e.n = n;
    e.start_cyc = cyc;
    start_i = 1'b1;
    num_subgraph_i = SG_W'(n);
    sb_q.push_back(e);
  endtask

  task automatic wait_done(int target, int budget, string name);
    for (int i = 0; i < budget; i++) begin
      if (batches_done >= target) break;
      step();
    end
    check(name, batches_done >= target, 1);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_starts"}, starts, 0);
    check({tag, "_cur"}, cur_subgraph_o, 0);
    check({tag, "_perf_cyc"}, perf_cycles_o, 0);
    check({tag, "_perf_stall"}, perf_stall_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt;
    int s_cyc;
    int exp_stall;
    int exp_cycles;
    int n;
    int exp_blocked;

    start_i = 1'b0;
    num_subgraph_i = '0;
    t_rdy = '0;
    t_vld = '0;
    for (int s = 0; s < 4; s++) timer[s] = 0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // N=1, fixed latency 5
    tgt = batches_done + 1;
    start_batch(1);
    wait_done(tgt, 200, "n1_timeout");
    step();

    // N=0
    tgt = batches_done + 1;
    start_batch(0);
    wait_done(tgt, 20, "n0_timeout");
    step();

    // N=4 with DMVM held not-ready: SPMM can only fill the buffer
    n = 4;
    exp_blocked = (n < int'(BD)) ? n : int'(BD);
    rdy_force_lo = 4'b0010;
    tgt = batches_done + 1;
    start_batch(n);
    repeat (40) step();
    check("spmm_blocked_count", scnt[0], exp_blocked);
    rdy_force_lo = '0;
    wait_done(tgt, 400, "n4_timeout");
    step();

    // Stray SM completion while idle
    t_vld[2] = 1'b1;
    step();
    check("err_set", err_o, 1);
    check("err_cur_unchanged", cur_subgraph_o, n);
    repeat (5) step();
    check("err_sticky", err_o, 1);
    tgt = batches_done + 1;
    start_batch(2);
    step();
    check("err_cleared", err_o, 0);
    wait_done(tgt, 300, "err_batch_timeout");
    step();

    // Perf: AGGR held not-ready for 10 cycles once it has work
    rdy_force_lo = 4'b1000;
    tgt = batches_done + 1;
    s_cyc = cyc;
    start_batch(1);
    for (int i = 0; i < 200; i++) begin
      step();
      if (t_vld[2]) break;
    end
    check("perf_sm_vld_seen", t_vld[2], 1);
    repeat (10) step();
    rdy_force_lo = '0;
    wait_done(tgt, 200, "perf_timeout");
    repeat (3) step();
`ifdef GAT_SCHED_PERF_EN
    exp_stall = 10;
    exp_cycles = last_aggr_vld - s_cyc;
`else
    exp_stall = 0;
    exp_cycles = 0;
`endif
    check("perf_stall", perf_stall_o, exp_stall);
    check("perf_cycles", perf_cycles_o, exp_cycles);

    // Randomized batches with random ready and latency
    rdy_rand = 1;
    lat_min = 1;
    lat_max = 6;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(6, 0);
      tgt = batches_done + 1;
      start_batch(n);
      repeat (2) step();
      start_i = 1'b1;                       // must be ignored (RUN or DONE)
      num_subgraph_i = SG_W'($urandom_range(9, 7));
      wait_done(tgt, 600, $sformatf("rand%0d_timeout", k));
      step();
    end

    // Reset in the middle of an N=3 batch after one completion
    rdy_rand = 0;
    lat_min = 3;
    lat_max = 3;
    start_batch(3);
    for (int i = 0; i < 300; i++) begin
      step();
      if (vcnt[3] >= 1) break;
    end
    check("rst_one_completion", vcnt[3] >= 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    sb_q.delete();
    for (int s = 0; s < 4; s++) timer[s] = 0;
    t_vld = '0;
    start_i = 1'b0;
    repeat (2) step();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    step();
    tgt = batches_done + 1;
    start_batch(2);
    wait_done(tgt, 200, "post_rst_timeout");
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gat_stage_scheduler.md
Name: gat_stage_scheduler

Overview:
- Token-based scheduler for the four GAT layer stages: SPMM (sparse H×W), DMVM (attention coefficients), SM (softmax) and AGGR (aggregation).
- Processes a batch of N sub-graphs. It issues one-cycle start pulses to each stage and tracks completions. Stages overlap in pipeline fashion, limited by inter-stage buffer depth.
- Sits above the stage engines and drives their start strobes from the top-level run command.

Parameters:
- SG_W, 16, width of sub-graph counters and num_subgraph_i.
- BUF_DEPTH, 2, result slots between consecutive stages (ping-pong); legal 1..4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  run command pulse; sampled only in IDLE
- num_subgraph_i  in  SG_W  sub-graph count, latched on accepted start_i
- busy_o  out  1  high in RUN and DONE
- done_o  out  1  one-cycle pulse when the batch completes
- err_o  out  1  sticky; set by a vld pulse from a stage that is not busy
- spmm_start_o / dmvm_start_o / sm_start_o / aggr_start_o  out  1 each  registered one-cycle start pulse
- spmm_rdy_i / dmvm_rdy_i / sm_rdy_i / aggr_rdy_i  in  1 each  stage able to accept a start
- spmm_vld_i / dmvm_vld_i / sm_vld_i / aggr_vld_i  in  1 each  one-cycle completion pulse
- cur_subgraph_o  out  SG_W  number of sub-graphs completed by AGGR
- perf_cycles_o  out  32  RUN cycle count (see Optional Feature)
- perf_stall_o  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset values: all outputs 0; all counters 0; all busy flags 0; state IDLE.
- Reset mid-operation aborts the batch immediately; no done_o pulse is produced.
- FSM states and transitions:
  - IDLE: on start_i, latch N=num_subgraph_i, clear all counters and err_o, go to RUN.
  - RUN: go to DONE when done[AGGR]==N.
  - DONE: done_o=1 for one cycle, then IDLE.
- N==0: RUN lasts one cycle with no start pulses; done_o is asserted 2 cycles after start_i.
- start_i in RUN or DONE is ignored.
- Per-stage state, for s = 0..3 (SPMM, DMVM, SM, AGGR):
  - busy[s] flag.
  - issued[s] and done[s] counters, SG_W bits, never wrap. N is the ceiling, so no modular compare is needed.
- Issue condition for stage s, evaluated on registered state in RUN:
  - !busy[s], and rdy_s, and no start_o of stage s asserted this cycle;
  - issued[s] < N for s=0, or issued[s] < done[s-1] for s>0;
  - for s<3: done[s] - issued[s+1] < BUF_DEPTH (downstream buffer slot free).
- On issue: start_o is high the next cycle, busy[s] is set and issued[s] is incremented on the same edge.
- On vld_s while busy[s]: busy[s] clears and done[s] increments.
- On vld_s while !busy[s]: err_o is set and the counters are untouched.
- vld and a new start decision for the same stage cannot coincide, because issue uses the registered busy flag. Minimum restart gap is 1 bubble cycle.
- Latency:
  - start_i sampled at edge t → earliest spmm_start_o high in cycle t+2.
  - vld of stage s-1 in cycle c → earliest start_o of stage s in cycle c+2.
  - Final aggr_vld_i in cycle c → done_o in cycle c+1.
- Multiple stages may issue in the same cycle; no priority is needed because each stage is independent.
- cur_subgraph_o = done[AGGR].

Optional Feature:
- Macro: GAT_SCHED_PERF_EN.
- Defined:
  - perf_cycles_o counts cycles in RUN.
  - perf_stall_o counts RUN cycles where some stage has work available (the upstream condition holds) and !busy, but is blocked by !rdy or a full buffer.
  - Both counters clear on an accepted start_i, saturate at 2^32-1 and hold their value after DONE.
- Not defined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- N=1, all rdy=1, each stage returns vld 5 cycles after start → each start_o pulses exactly once in order SPMM, DMVM, SM, AGGR; done_o pulses once; cur_subgraph_o=1; err_o=0.
- N=4, BUF_DEPTH=2, dmvm_rdy_i held 0 for 40 cycles → spmm_start_o pulses exactly 2 times then stops; resumes after dmvm_rdy_i rises; final counts are 4 per stage and done_o=1.
- N=0 → done_o exactly 2 cycles after start_i; no start_o pulses.
- Stray sm_vld_i while SM idle → err_o=1 and stays 1 until the next accepted start_i; counters unchanged.
- rst_n low mid-batch (N=3, after 1 completion) → all outputs 0 asynchronously; a new start_i with N=2 completes normally with cur_subgraph_o=2.
- With GAT_SCHED_PERF_EN, N=1, aggr_rdy_i held 0 for 10 cycles once AGGR has work → perf_stall_o=10, and perf_cycles_o equals the RUN duration.
